// File: rtl/button_debounce_pkg.sv
// button_debounce_pkg: shared channel state type, timing defaults and timestamp width
package button_debounce_pkg;
  localparam int TS_W = 32;
  localparam int unsigned DEBOUNCE_US_DEF = 5000;
  localparam int unsigned LONG_US_DEF = 1000000;
  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    LONG_HELD,
    RELEASE_WAIT
  } ch_state_t;
endpackage

// File: rtl/btn_channel.sv
// btn_channel: synchronizer, debounce/long-press FSM and timestamps for one button
// clk/rst (async, active-low), time_micro (us timestamp), raw (async button),
// level (debounced), press_pulse/release_pulse/long_pulse (one-cycle events)
module btn_channel
  import button_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_US = DEBOUNCE_US_DEF,
  parameter int unsigned LONG_US = LONG_US_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [TS_W-1:0] time_micro,
  input  logic            raw,
  output logic            level,
  output logic            press_pulse,
  output logic            release_pulse,
  output logic            long_pulse
);
  localparam logic [TS_W-1:0] DEB_T = TS_W'(DEBOUNCE_US);
  localparam logic [TS_W-1:0] LONG_T = TS_W'(LONG_US);
  logic meta, sync;
  ch_state_t state, state_nx;
  logic [TS_W-1:0] stamp, stamp_nx, press_stamp, press_stamp_nx;
  logic long_done, long_done_nx;
  logic level_nx, press_nx, release_nx, long_nx;
  logic [TS_W-1:0] elapsed;
  // modulo-2^32 subtraction keeps intervals exact across timestamp wrap
  assign elapsed = time_micro - stamp;
  always_comb begin
    state_nx = state;
    stamp_nx = stamp;
    press_stamp_nx = press_stamp;
    long_done_nx = long_done;
    level_nx = level;
    press_nx = 1'b0;
    release_nx = 1'b0;
    long_nx = 1'b0;
    case (state)
      IDLE: if (sync) begin
        state_nx = PRESS_WAIT;
        stamp_nx = time_micro;
      end
      PRESS_WAIT: if (!sync) state_nx = IDLE;
      else if (elapsed >= DEB_T) begin
        state_nx = HELD;
        level_nx = 1'b1;
        press_nx = 1'b1;
        stamp_nx = time_micro;
        press_stamp_nx = time_micro;
        long_done_nx = 1'b0;
      end
      // release is checked first so it wins over a coincident long threshold
      HELD: if (!sync) begin
        state_nx = RELEASE_WAIT;
        stamp_nx = time_micro;
      end else if (elapsed >= LONG_T) begin
        state_nx = LONG_HELD;
        long_nx = 1'b1;
        long_done_nx = 1'b1;
      end
      LONG_HELD: if (!sync) begin
        state_nx = RELEASE_WAIT;
        stamp_nx = time_micro;
      end
      // a release glitch resumes the hold timed from the original press
      RELEASE_WAIT: if (sync) begin
        state_nx = long_done ? LONG_HELD : HELD;
        stamp_nx = press_stamp;
      end else if (elapsed >= DEB_T) begin
        state_nx = IDLE;
        level_nx = 1'b0;
        release_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      state <= IDLE;
      stamp <= '0;
      press_stamp <= '0;
      long_done <= 1'b0;
      level <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      state <= state_nx;
      stamp <= stamp_nx;
      press_stamp <= press_stamp_nx;
      long_done <= long_done_nx;
      level <= level_nx;
      press_pulse <= press_nx;
      release_pulse <= release_nx;
      long_pulse <= long_nx;
    end
  end
endmodule

// File: rtl/button_debounce.sv
// button_debounce: N independent debounced buttons with press/release/long-press pulses
// clk/rst (async, active-low), time_micro (us timestamp), btn_raw (async buttons),
// btn_level (debounced), press_pulse/release_pulse/long_pulse (one-cycle per channel)
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int unsigned N_BTN = 3,
  parameter int unsigned DEBOUNCE_US = DEBOUNCE_US_DEF,
  parameter int unsigned LONG_US = LONG_US_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TS_W-1:0]  time_micro,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_US(DEBOUNCE_US),
      .LONG_US(LONG_US)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .time_micro(time_micro),
      .raw(btn_raw[i]),
      .level(btn_level[i]),
      .press_pulse(press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse(long_pulse[i])
    );
  end
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: table-driven and directed checks of button_debounce (DEBOUNCE_US=10, LONG_US=100)
module tb_button_debounce;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] time_micro = 32'd100;
  logic [2:0] btn_raw = 3'b000;
  logic [2:0] btn_level, press_pulse, release_pulse, long_pulse;
  int checks = 0;
  int errors = 0;
  int sub = 0;
  int n_p, n_r, n_l;
  logic got_p, got_r, got_l;
  logic [31:0] t_p, t_r, t_l, t0;
  logic [2:0] v_p;
  typedef struct {
    logic [2:0] raw;
    int dur;
    logic [2:0] lvl;
    int np;
    int nr;
    int nl;
  } seg_t;
  seg_t tab[$];
  button_debounce #(.N_BTN(3), .DEBOUNCE_US(10), .LONG_US(100)) dut (
    .clk(clk),
    .rst(rst),
    .time_micro(time_micro),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  task automatic clr();
    n_p = 0;
    n_r = 0;
    n_l = 0;
    got_p = 1'b0;
    got_r = 1'b0;
    got_l = 1'b0;
    t_p = '0;
    t_r = '0;
    t_l = '0;
    v_p = '0;
  endtask
  // four clocks per microsecond; outputs sampled 1ns after each rising edge
  task automatic clocks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      n_p += $countones(press_pulse);
      n_r += $countones(release_pulse);
      n_l += $countones(long_pulse);
      if (press_pulse != 0 && !got_p) begin
        got_p = 1'b1;
        t_p = time_micro;
        v_p = press_pulse;
      end
      if (release_pulse != 0 && !got_r) begin
        got_r = 1'b1;
        t_r = time_micro;
      end
      if (long_pulse != 0 && !got_l) begin
        got_l = 1'b1;
        t_l = time_micro;
      end
      sub++;
      if (sub == 4) begin
        sub = 0;
        time_micro++;
      end
    end
  endtask
  task automatic us(input int n);
    clocks(4 * n);
  endtask
  function automatic void add(input logic [2:0] raw, input int dur, input logic [2:0] lvl,
                              input int np, input int nr, input int nl);
    tab.push_back('{raw, dur, lvl, np, nr, nl});
  endfunction
  initial begin
    add(3'b000, 5, 3'b000, 0, 0, 0);
    add(3'b001, 20, 3'b001, 1, 0, 0);
    add(3'b000, 20, 3'b000, 0, 1, 0);
    for (int k = 0; k < 10; k++) add(k[0] ? 3'b000 : 3'b001, 3, 3'b000, 0, 0, 0);
    add(3'b000, 20, 3'b000, 0, 0, 0);
    add(3'b010, 150, 3'b010, 1, 0, 1);
    add(3'b000, 20, 3'b000, 0, 1, 0);
    add(3'b100, 5, 3'b000, 0, 0, 0);
    add(3'b000, 5, 3'b000, 0, 0, 0);
    add(3'b100, 60, 3'b100, 1, 0, 0);
    add(3'b000, 4, 3'b100, 0, 0, 0);
    add(3'b100, 60, 3'b100, 0, 0, 1);
    add(3'b000, 20, 3'b000, 0, 1, 0);
    add(3'b001, 120, 3'b001, 1, 0, 1);
    add(3'b000, 4, 3'b001, 0, 0, 0);
    add(3'b001, 30, 3'b001, 0, 0, 0);
    add(3'b000, 20, 3'b000, 0, 1, 0);
    clr();
    clocks(4);
    chk("reset_outputs", {btn_level, press_pulse, release_pulse, long_pulse}, 12'h000);
    rst = 1'b1;
    foreach (tab[i]) begin
      btn_raw = tab[i].raw;
      clr();
      us(tab[i].dur);
      chk($sformatf("seg%0d_press", i), n_p, tab[i].np);
      chk($sformatf("seg%0d_release", i), n_r, tab[i].nr);
      chk($sformatf("seg%0d_long", i), n_l, tab[i].nl);
      chk($sformatf("seg%0d_level", i), btn_level, tab[i].lvl);
    end
    t0 = time_micro;
    btn_raw = 3'b001;
    clr();
    us(20);
    chk("clean_press_time", t_p, t0 + 32'd10);
    t0 = time_micro;
    btn_raw = 3'b000;
    us(20);
    chk("clean_release_time", t_r, t0 + 32'd10);
    t0 = time_micro;
    btn_raw = 3'b010;
    clr();
    us(150);
    chk("long_time", t_l, t0 + 32'd110);
    btn_raw = 3'b000;
    us(20);
    chk("long_counts", {n_p, n_l, n_r}, {32'd1, 32'd1, 32'd1});
    time_micro = 32'hFFFF_FFF8;
    btn_raw = 3'b001;
    clr();
    us(20);
    chk("wrap_press_time", t_p, 32'h0000_0002);
    chk("wrap_press_count", n_p, 1);
    btn_raw = 3'b000;
    us(20);
    chk("wrap_release_count", n_r, 1);
    btn_raw = 3'b001;
    clr();
    clocks(438);
    btn_raw = 3'b000;
    clocks(2);
    us(20);
    chk("tie_release_wins", {n_p, n_l, n_r}, {32'd1, 32'd0, 32'd1});
    btn_raw = 3'b001;
    clr();
    clocks(439);
    btn_raw = 3'b000;
    clocks(1);
    us(20);
    chk("late_release_long", {n_p, n_l, n_r}, {32'd1, 32'd1, 32'd1});
    btn_raw = 3'b001;
    clr();
    us(15);
    chk("pre_reset_level", btn_level, 3'b001);
    rst = 1'b0;
    #1;
    chk("reset_immediate", {btn_level, press_pulse, release_pulse, long_pulse}, 12'h000);
    clr();
    clocks(8);
    t0 = time_micro;
    rst = 1'b1;
    us(20);
    chk("reset_no_release", n_r, 0);
    chk("reset_repress_time", t_p, t0 + 32'd10);
    chk("reset_repress_level", btn_level, 3'b001);
    btn_raw = 3'b000;
    us(20);
    t0 = time_micro;
    clr();
    for (int k = 0; k < 5; k++) begin
      btn_raw = k[0] ? 3'b101 : 3'b111;
      us(3);
    end
    btn_raw = 3'b101;
    us(5);
    chk("multi_press_vec", v_p, 3'b101);
    chk("multi_press_time", t_p, t0 + 32'd10);
    chk("multi_press_count", n_p, 2);
    btn_raw = 3'b000;
    us(20);
    chk("multi_release_count", n_r, 2);
    chk("multi_level", btn_level, 3'b000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
